// File: rtl/axi_bram_responder_pkg.sv
// axi_bram_responder_pkg: burst, response and responder state types shared by the BRAM responder
package axi_bram_responder_pkg;
  typedef enum logic [1:0] {FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2} burst_t;
  typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_t;
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;
endpackage

// File: rtl/axi_bram_responder_if.sv
// axi_bram_responder_if: AXI4 channel bundle between the memory adapter master and the BRAM responder
interface axi_bram_responder_if #(
  parameter int id_width   = 4,
  parameter int addr_width = 32,
  parameter int data_width = 32
);
  logic [id_width-1:0]     awid;
  logic [addr_width-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic                    awvalid;
  logic                    awready;
  logic [data_width-1:0]   wdata;
  logic [data_width/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [id_width-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [id_width-1:0]     arid;
  logic [addr_width-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic                    arvalid;
  logic                    arready;
  logic [id_width-1:0]     rid;
  logic [data_width-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_bram_responder_bram_byte_we.sv
// bram_byte_we: single-port block RAM with per-byte write enables and a registered read
module bram_byte_we #(
  parameter int depth_log2 = 12,
  parameter int data_width = 32
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [data_width/8-1:0] we,
  input  logic [depth_log2-1:0]   addr,
  input  logic [data_width-1:0]   wdata,
  output logic [data_width-1:0]   rdata
);
  logic [data_width-1:0] mem [2**depth_log2];
  always_ff @(posedge clk)
    if (en) begin
      for (int i = 0; i < data_width / 8; i++)
        if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      rdata <= mem[addr];
    end
endmodule

// File: rtl/axi_bram_responder.sv
// axi_bram_responder: single-transaction AXI4 slave backed by byte-writable block RAM
module axi_bram_responder
  import axi_bram_responder_pkg::*;
#(
  parameter int id_width   = 4,
  parameter int addr_width = 32,
  parameter int data_width = 32,
  parameter int depth_log2 = 12
) (
  input logic clk,
  input logic reset,
  axi_bram_responder_if.slave axi
);
  localparam int nb = data_width / 8;
  state_t state, state_n;
  burst_t burst;
  logic [id_width-1:0] id;
  logic [depth_log2-1:0] addr;
  logic [7:0] len, wcnt, rbeat;
  logic [8:0] icnt;
  logic [1:0] occ;
  logic [data_width-1:0] r_q, s_q, ram_q;
  logic last_wr, err_wlast, grant_w, grant_r, aw_hs, ar_hs, w_hs, r_hs, w_end, r_end;
  logic ren, pv, r_full, s_full, rv, unused_ok;
  assign unused_ok = &{1'b0, axi.awsize, axi.arsize, axi.awlock, axi.arlock, axi.awcache,
                       axi.arcache, axi.awprot, axi.arprot, axi.awqos, axi.arqos,
                       axi.awaddr[addr_width-1:depth_log2+2], axi.awaddr[1:0],
                       axi.araddr[addr_width-1:depth_log2+2], axi.araddr[1:0]};
  // On a tie the channel not served last wins; write wins first after reset
  assign grant_w = axi.awvalid & (~axi.arvalid | ~last_wr);
  assign grant_r = axi.arvalid & ~grant_w;
  assign aw_hs = axi.awvalid & axi.awready;
  assign ar_hs = axi.arvalid & axi.arready;
  assign w_hs = axi.wvalid & axi.wready;
  assign r_hs = axi.rvalid & axi.rready;
  assign w_end = w_hs & (wcnt == len);
  assign r_end = r_hs & axi.rlast;
  // Entries held in the output/skid registers plus the word arriving from RAM, after this cycle's pop
  assign occ = 2'(r_full) + 2'(s_full) + 2'(pv) - 2'(r_hs);
  assign ren = (state == RD_ADDR) | ((state == RD_DATA) & (icnt <= {1'b0, len}) & (occ < 2'd2));
  bram_byte_we #(.depth_log2(depth_log2), .data_width(data_width)) u_ram (
    .clk(clk),
    .en((ren | w_hs) & ~reset),
    .we({nb{w_hs & ~reset}} & axi.wstrb),
    .addr(addr),
    .wdata(axi.wdata),
    .rdata(ram_q)
  );
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = aw_hs ? WR_DATA : ar_hs ? RD_ADDR : IDLE;
      WR_DATA: state_n = w_end ? WR_RESP : WR_DATA;
      WR_RESP: state_n = axi.bready ? IDLE : WR_RESP;
      RD_ADDR: state_n = RD_DATA;
      RD_DATA: state_n = r_end ? IDLE : RD_DATA;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    rv = (state == RD_DATA) & (r_full | pv);
    axi.awready = (state == IDLE) & grant_w & ~reset;
    axi.arready = (state == IDLE) & grant_r & ~reset;
    axi.wready = state == WR_DATA;
    axi.bvalid = state == WR_RESP;
    axi.bid = id;
    axi.bresp = OKAY;
    axi.rvalid = rv;
    axi.rdata = r_full ? r_q : pv ? ram_q : '0;
    axi.rid = id;
    axi.rresp = OKAY;
    axi.rlast = rv & (rbeat == len);
  end
  always_ff @(posedge clk)
    if (reset) begin
      burst <= INCR;
      id <= '0;
      addr <= '0;
      len <= '0;
      wcnt <= '0;
      rbeat <= '0;
      icnt <= '0;
      last_wr <= 1'b0;
      err_wlast <= 1'b0;
      pv <= 1'b0;
      r_full <= 1'b0;
      s_full <= 1'b0;
      r_q <= '0;
      s_q <= '0;
    end else begin
      pv <= ren;
      if (aw_hs) begin
        id <= axi.awid;
        addr <= axi.awaddr[depth_log2+1:2];
        len <= axi.awlen;
        burst <= burst_t'(axi.awburst);
        wcnt <= '0;
        last_wr <= 1'b1;
      end
      if (ar_hs) begin
        id <= axi.arid;
        addr <= axi.araddr[depth_log2+1:2];
        len <= axi.arlen;
        burst <= burst_t'(axi.arburst);
        rbeat <= '0;
        icnt <= '0;
        last_wr <= 1'b0;
      end
      if (w_hs) begin
        wcnt <= wcnt + 8'd1;
        err_wlast <= err_wlast | (axi.wlast != (wcnt == len));
      end
      if (w_hs | ren) addr <= (burst == FIXED) ? addr : addr + depth_log2'(1);
      if (ren) icnt <= icnt + 9'd1;
      if (r_hs) rbeat <= rbeat + 8'd1;
      // Oldest word sits in r_q, the next in s_q; RAM output drains into whichever is free
      if (r_hs) begin
        r_full <= r_full & (s_full | pv);
        r_q <= s_full ? s_q : ram_q;
        s_full <= 1'b0;
      end else if (!r_full) begin
        r_full <= pv;
        r_q <= ram_q;
      end else if (!s_full) begin
        s_full <= pv;
        s_q <= ram_q;
      end
    end
endmodule

// File: tb/tb_axi_bram_responder.sv
// tb_axi_bram_responder: directed self-checking bench for the AXI4 BRAM responder
module tb_axi_bram_responder;
  import axi_bram_responder_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int fails = 0;
  logic [31:0] rd_buf [0:15];
  axi_bram_responder_if axi();
  axi_bram_responder dut (.clk(clk), .reset(reset), .axi(axi));
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic init_inputs();
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = 3'd2; axi.awburst = 2'd1;
    axi.awlock = 1'b0; axi.awcache = '0; axi.awprot = '0; axi.awqos = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'd2; axi.arburst = 2'd1;
    axi.arlock = 1'b0; axi.arcache = '0; axi.arprot = '0; axi.arqos = '0; axi.arvalid = 1'b0;
    axi.rready = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [1:0] bt);
    int g;
    logic ok;
    axi.awid = id; axi.awaddr = a; axi.awlen = len; axi.awburst = bt; axi.awvalid = 1'b1;
    g = 0;
    ok = 1'b0;
    do begin
      #2;
      ok = axi.awready;
      @(posedge clk);
      #1;
      g++;
    end while (!ok && g < 50);
    axi.awvalid = 1'b0;
    checks++;
    if (!ok) begin fails++; $display("FAIL aw_handshake: awready got 0 expected 1"); end
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [1:0] bt);
    int g;
    logic ok;
    axi.arid = id; axi.araddr = a; axi.arlen = len; axi.arburst = bt; axi.arvalid = 1'b1;
    g = 0;
    ok = 1'b0;
    do begin
      #2;
      ok = axi.arready;
      @(posedge clk);
      #1;
      g++;
    end while (!ok && g < 50);
    axi.arvalid = 1'b0;
    checks++;
    if (!ok) begin fails++; $display("FAIL ar_handshake: arready got 0 expected 1"); end
  endtask

  task automatic write_data_resp(input logic [3:0] id, input logic [7:0] len, input logic [3:0] strb,
                                 input logic [31:0] base, input logic good_last);
    int g;
    logic ok;
    for (int i = 0; i <= int'(len); i++) begin
      axi.wdata = base + 32'(i); axi.wstrb = strb; axi.wlast = good_last && (i == int'(len)); axi.wvalid = 1'b1;
      g = 0;
      ok = 1'b0;
      do begin
        #2;
        ok = axi.wready;
        @(posedge clk);
        #1;
        g++;
      end while (!ok && g < 50);
      checks++;
      if (!ok) begin fails++; $display("FAIL w_handshake beat %0d: wready got 0 expected 1", i); end
    end
    axi.wvalid = 1'b0;
    axi.wlast = 1'b0;
    #1;
    checks++;
    if (axi.bvalid !== 1'b1) begin fails++; $display("FAIL b_latency: bvalid got %b expected 1", axi.bvalid); end
    checks++;
    if (axi.bid !== id) begin fails++; $display("FAIL bid: got %h expected %h", axi.bid, id); end
    checks++;
    if (axi.bresp !== 2'b00) begin fails++; $display("FAIL bresp: got %b expected 00", axi.bresp); end
    axi.bready = 1'b1;
    @(posedge clk);
    #1;
    axi.bready = 1'b0;
    #1;
    checks++;
    if (axi.bvalid !== 1'b0) begin fails++; $display("FAIL b_clear: bvalid got %b expected 0", axi.bvalid); end
    @(posedge clk);
    #1;
  endtask

  task automatic recv_r(input logic [3:0] id, input logic [7:0] len, input logic toggle);
    int b, k;
    logic hold, hl;
    logic [31:0] hd;
    #1;
    checks++;
    if (axi.rvalid !== 1'b0) begin fails++; $display("FAIL r_early: rvalid got %b expected 0 one cycle after AR", axi.rvalid); end
    @(posedge clk);
    #1;
    b = 0;
    k = 0;
    hold = 1'b0;
    hd = '0;
    hl = 1'b0;
    while (b <= int'(len) && k < 200) begin
      axi.rready = toggle ? (k % 3 == 0) : 1'b1;
      #2;
      if (k == 0) begin
        checks++;
        if (axi.rvalid !== 1'b1) begin fails++; $display("FAIL r_latency: rvalid got %b expected 1 two cycles after AR", axi.rvalid); end
      end
      if (hold) begin
        checks++;
        if (axi.rvalid !== 1'b1 || axi.rdata !== hd || axi.rlast !== hl) begin
          fails++;
          $display("FAIL r_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b", axi.rvalid, axi.rdata, axi.rlast, hd, hl);
        end
      end
      hold = axi.rvalid && !axi.rready;
      hd = axi.rdata;
      hl = axi.rlast;
      if (axi.rvalid && axi.rready) begin
        rd_buf[b] = axi.rdata;
        checks++;
        if (axi.rlast !== (b == int'(len))) begin fails++; $display("FAIL rlast beat %0d: got %b expected %b", b, axi.rlast, b == int'(len)); end
        checks++;
        if (axi.rid !== id || axi.rresp !== 2'b00) begin fails++; $display("FAIL rid_rresp: got %h/%b expected %h/00", axi.rid, axi.rresp, id); end
        b++;
      end
      @(posedge clk);
      #1;
      k++;
    end
    axi.rready = 1'b0;
    checks++;
    if (b != int'(len) + 1) begin fails++; $display("FAIL r_timeout: beats got %0d expected %0d", b, int'(len) + 1); end
    if (!toggle) begin
      checks++;
      if (k != int'(len) + 1) begin fails++; $display("FAIL r_throughput: cycles got %0d expected %0d", k, int'(len) + 1); end
    end
    #1;
    checks++;
    if (axi.rvalid !== 1'b0) begin fails++; $display("FAIL r_done: rvalid got %b expected 0", axi.rvalid); end
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [1:0] bt,
                             input logic [3:0] strb, input logic [31:0] base, input logic good_last);
    send_aw(id, a, len, bt);
    write_data_resp(id, len, strb, base, good_last);
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [1:0] bt,
                            input logic toggle);
    send_ar(id, a, len, bt);
    recv_r(id, len, toggle);
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if ({axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid, axi.rlast} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 000000", {axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid, axi.rlast});
    end
    checks++;
    if (axi.rdata !== 32'h0 || axi.bid !== 4'h0 || axi.rid !== 4'h0 || axi.bresp !== 2'b00 || axi.rresp !== 2'b00) begin
      fails++;
      $display("FAIL reset_values: rdata=%h bid=%h rid=%h expected zeros", axi.rdata, axi.bid, axi.rid);
    end
    checks++;
    if (dut.state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected IDLE", dut.state); end
    axi.awvalid = 1'b1;
    #2;
    checks++;
    if ({axi.awready, axi.arready} !== 2'b10) begin fails++; $display("FAIL aw_only_grant: got %b expected 10", {axi.awready, axi.arready}); end
    axi.awvalid = 1'b0;
    axi.arvalid = 1'b1;
    #1;
    checks++;
    if ({axi.awready, axi.arready} !== 2'b01) begin fails++; $display("FAIL ar_only_grant: got %b expected 01", {axi.awready, axi.arready}); end
    axi.arvalid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_incr_burst();
    write_burst(4'h3, 32'h100, 8'd3, INCR, 4'hF, 32'd1, 1'b1);
    read_burst(4'h9, 32'h100, 8'd3, INCR, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_buf[i] !== 32'(i + 1)) begin fails++; $display("FAIL incr_data[%0d]: got %h expected %h", i, rd_buf[i], i + 1); end
    end
  endtask

  task automatic test_strobe();
    write_burst(4'h1, 32'h40, 8'd0, INCR, 4'hF, 32'hAABBCCDD, 1'b1);
    write_burst(4'h2, 32'h40, 8'd0, INCR, 4'b0101, 32'h11223344, 1'b1);
    read_burst(4'h4, 32'h40, 8'd0, INCR, 1'b0);
    checks++;
    if (rd_buf[0] !== 32'hAA22CC44) begin fails++; $display("FAIL strobe_merge: got %h expected AA22CC44", rd_buf[0]); end
  endtask

  task automatic test_rready_toggle();
    write_burst(4'h5, 32'h200, 8'd7, INCR, 4'hF, 32'h1000, 1'b1);
    read_burst(4'h6, 32'h200, 8'd7, INCR, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_buf[i] !== 32'h1000 + 32'(i)) begin fails++; $display("FAIL toggle_data[%0d]: got %h expected %h", i, rd_buf[i], 32'h1000 + 32'(i)); end
    end
  endtask

  task automatic test_arbitration();
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      logic [3:0] wid, aid;
      wid = 4'(2 * i + 1);
      aid = 4'(2 * i + 2);
      axi.awid = wid; axi.awaddr = 32'h300; axi.awlen = 8'd0; axi.awburst = INCR;
      axi.arid = aid; axi.araddr = 32'h100; axi.arlen = 8'd0; axi.arburst = INCR;
      axi.awvalid = 1'b1;
      axi.arvalid = 1'b1;
      #2;
      checks++;
      if ({axi.awready, axi.arready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL arb_round%0d: got %b expected %b", i, {axi.awready, axi.arready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      @(posedge clk);
      #1;
      axi.awvalid = 1'b0;
      axi.arvalid = 1'b0;
      if (i % 2 == 0) write_data_resp(wid, 8'd0, 4'hF, 32'h300 + 32'(i), 1'b1);
      else begin
        recv_r(aid, 8'd0, 1'b0);
        checks++;
        if (rd_buf[0] !== 32'd1) begin fails++; $display("FAIL arb_rdata%0d: got %h expected 1", i, rd_buf[0]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int g;
    logic ok;
    write_burst(4'h1, 32'h508, 8'd0, INCR, 4'hF, 32'h0BAD0508, 1'b1);
    send_aw(4'h2, 32'h500, 8'd7, INCR);
    for (int i = 0; i < 2; i++) begin
      axi.wdata = 32'h50 + 32'(i); axi.wstrb = 4'hF; axi.wvalid = 1'b1;
      g = 0;
      ok = 1'b0;
      do begin
        #2;
        ok = axi.wready;
        @(posedge clk);
        #1;
        g++;
      end while (!ok && g < 50);
      checks++;
      if (!ok) begin fails++; $display("FAIL mid_w_handshake beat %0d: wready got 0 expected 1", i); end
    end
    axi.wdata = 32'h52;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    axi.wvalid = 1'b0;
    #1;
    checks++;
    if ({axi.wready, axi.bvalid, axi.rvalid, axi.awready, axi.arready} !== 5'b0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %b expected 00000", {axi.wready, axi.bvalid, axi.rvalid, axi.awready, axi.arready});
    end
    checks++;
    if (dut.state !== IDLE) begin fails++; $display("FAIL mid_reset_state: got %0d expected IDLE", dut.state); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (axi.bvalid !== 1'b0) begin fails++; $display("FAIL mid_no_bvalid: got %b expected 0", axi.bvalid); end
    read_burst(4'h3, 32'h500, 8'd1, INCR, 1'b0);
    checks++;
    if (rd_buf[0] !== 32'h50 || rd_buf[1] !== 32'h51) begin fails++; $display("FAIL mid_kept: got %h %h expected 50 51", rd_buf[0], rd_buf[1]); end
    read_burst(4'h4, 32'h508, 8'd0, INCR, 1'b0);
    checks++;
    if (rd_buf[0] !== 32'h0BAD0508) begin fails++; $display("FAIL mid_beat2: got %h expected 0BAD0508", rd_buf[0]); end
  endtask

  task automatic test_wrap_fixed();
    write_burst(4'h7, 32'h3FFC, 8'd3, INCR, 4'hF, 32'hA0, 1'b1);
    read_burst(4'h8, 32'h3FFC, 8'd3, INCR, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_buf[i] !== 32'hA0 + 32'(i)) begin fails++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, rd_buf[i], 32'hA0 + 32'(i)); end
    end
    read_burst(4'h9, 32'h0, 8'd0, INCR, 1'b0);
    checks++;
    if (rd_buf[0] !== 32'hA1) begin fails++; $display("FAIL wrap_word0: got %h expected A1", rd_buf[0]); end
    write_burst(4'hA, 32'h604, 8'd0, INCR, 4'hF, 32'hDEAD0604, 1'b1);
    write_burst(4'hB, 32'h600, 8'd3, FIXED, 4'hF, 32'hB0, 1'b1);
    read_burst(4'hC, 32'h600, 8'd1, INCR, 1'b0);
    checks++;
    if (rd_buf[0] !== 32'hB3) begin fails++; $display("FAIL fixed_last: got %h expected B3", rd_buf[0]); end
    checks++;
    if (rd_buf[1] !== 32'hDEAD0604) begin fails++; $display("FAIL fixed_neighbour: got %h expected DEAD0604", rd_buf[1]); end
  endtask

  task automatic test_wlast_err();
    checks++;
    if (dut.err_wlast !== 1'b0) begin fails++; $display("FAIL err_wlast_clean: got %b expected 0", dut.err_wlast); end
    write_burst(4'hD, 32'h700, 8'd1, INCR, 4'hF, 32'hC0, 1'b0);
    checks++;
    if (dut.err_wlast !== 1'b1) begin fails++; $display("FAIL err_wlast_set: got %b expected 1", dut.err_wlast); end
    read_burst(4'hE, 32'h700, 8'd1, INCR, 1'b0);
    checks++;
    if (rd_buf[1] !== 32'hC1) begin fails++; $display("FAIL err_wlast_data: got %h expected C1", rd_buf[1]); end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_incr_burst();
    test_strobe();
    test_rready_toggle();
    test_arbitration();
    test_reset_mid();
    test_wrap_fixed();
    test_wlast_err();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
